// File: rtl/irq_csr_pkg.sv
// Shared constants and types for the machine-mode interrupt CSR unit.
// Includes the CSR read-modify-write helper used by every writable register.
package irq_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [4:0] CAUSE_MSI = 5'd3;
   localparam logic [4:0] CAUSE_MTI = 5'd7;
   localparam logic [4:0] CAUSE_MEI = 5'd11;

   localparam int LOCAL_BASE = 16;

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } irq_state_t;

   function automatic logic [31:0] csr_apply(input logic [31:0] old_value,
                                             input logic [31:0] operand,
                                             input logic [1:0]  op);
      case (op)
         OP_WRITE: csr_apply = operand;
         OP_SET:   csr_apply = old_value | operand;
         OP_CLEAR: csr_apply = old_value & ~operand;
         default:  csr_apply = old_value;
      endcase
   endfunction

endpackage

// File: rtl/m_irq_csr_unit_prio.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > locals (lowest index first).
// Callers present only architected bits, so any set bit makes the vector valid.
module irq_prio_enc
   import irq_csr_pkg::*;
#(
   parameter int WIDTH = 20
) (
   input  logic [WIDTH-1:0] eligible,
   output logic             valid,
   output logic [4:0]       cause
);

   always_comb begin
      valid = |eligible;
      cause = '0;
      // Scan locals from the top so the lowest index is the last to win.
      for (int i = WIDTH - 1; i >= LOCAL_BASE; i--) begin
         if (eligible[i]) cause = 5'(i);
      end
      if (eligible[CAUSE_MTI]) cause = CAUSE_MTI;
      if (eligible[CAUSE_MSI]) cause = CAUSE_MSI;
      if (eligible[CAUSE_MEI]) cause = CAUSE_MEI;
   end

endmodule

// File: rtl/m_irq_csr_unit.sv
// Machine-mode mstatus/mie/mip register set with edge-latched local interrupts
// and a request/acknowledge handshake toward the trap sequencer.
module m_irq_csr_unit
   import irq_csr_pkg::*;
#(
   parameter int NUM_LOCAL = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [11:0]          csr_addr_in,
   input  logic                 csr_wr_en_in,
   input  logic [1:0]           csr_op_in,
   input  logic [31:0]          csr_wdata_in,
   output logic [31:0]          csr_rdata_out,
   input  logic                 ext_irq_in,
   input  logic                 sw_irq_in,
   input  logic                 timer_irq_in,
   input  logic [NUM_LOCAL-1:0] local_irq_in,
   input  logic                 trap_taken_in,
   input  logic                 mret_in,
   output logic                 irq_req_out,
   output logic [4:0]           irq_cause_out,
   input  logic                 irq_ack_in,
   output logic                 mie_out
);

   localparam int WIDTH = LOCAL_BASE + NUM_LOCAL;
   localparam logic [31:0] MIE_MASK =
      32'h0000_0888 | (((32'h1 << NUM_LOCAL) - 32'h1) << LOCAL_BASE);

   logic                 mstatus_mie, mstatus_mpie;
   logic [31:0]          mie_q;
   logic [NUM_LOCAL-1:0] pending, local_prev, local_edge, pend_clr;
   irq_state_t           state, state_next;
   logic [4:0]           cause_q, cause_next;
   logic [31:0]          mstatus_val, mip_val, csr_new, elig_ext;
   logic [WIDTH-1:0]     eligible;
   logic                 wr_any, wr_mstatus, wr_mie, wr_mip, ack_valid;
   logic                 win_valid;
   logic [4:0]           win_cause;

   always_comb begin
      mstatus_val    = 32'h0000_1800;
      mstatus_val[3] = mstatus_mie;
      mstatus_val[7] = mstatus_mpie;
      mip_val        = '0;
      mip_val[3]     = sw_irq_in;
      mip_val[7]     = timer_irq_in;
      mip_val[11]    = ext_irq_in;
      mip_val[LOCAL_BASE +: NUM_LOCAL] = pending;
      case (csr_addr_in)
         CSR_MSTATUS: csr_rdata_out = mstatus_val;
         CSR_MIE:     csr_rdata_out = mie_q;
         CSR_MIP:     csr_rdata_out = mip_val;
         default:     csr_rdata_out = '0;
      endcase
   end

   assign csr_new    = csr_apply(csr_rdata_out, csr_wdata_in, csr_op_in);
   assign wr_any     = csr_wr_en_in && (csr_op_in != OP_NONE);
   assign wr_mstatus = wr_any && (csr_addr_in == CSR_MSTATUS);
   assign wr_mie     = wr_any && (csr_addr_in == CSR_MIE);
   assign wr_mip     = wr_any && (csr_addr_in == CSR_MIP);
   assign ack_valid  = irq_ack_in && (state == ST_REQ);
   assign local_edge = local_irq_in & ~local_prev;

   assign eligible = mstatus_mie ? (mip_val[WIDTH-1:0] & mie_q[WIDTH-1:0]) : '0;
   assign elig_ext = 32'(eligible);

   always_comb begin
      pend_clr = '0;
      for (int i = 0; i < NUM_LOCAL; i++) begin
         pend_clr[i] = (wr_mip && !csr_new[LOCAL_BASE + i]) ||
                       (ack_valid && (cause_q == 5'(LOCAL_BASE + i)));
      end
   end

   irq_prio_enc #(.WIDTH(WIDTH)) u_prio (
      .eligible (eligible),
      .valid    (win_valid),
      .cause    (win_cause)
   );

   // A CSR write to mstatus outranks trap entry, which outranks mret.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b1;
      end else if (wr_mstatus) begin
         mstatus_mie  <= csr_new[3];
         mstatus_mpie <= csr_new[7];
      end else if (ack_valid || trap_taken_in) begin
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else if (mret_in) begin
         mstatus_mie  <= mstatus_mpie;
         mstatus_mpie <= 1'b1;
      end
   end

   // A new edge overrides any clear arriving in the same cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mie_q      <= '0;
         pending    <= '0;
         local_prev <= '0;
      end else begin
         if (wr_mie) mie_q <= csr_new & MIE_MASK;
         pending    <= (pending & ~pend_clr) | local_edge;
         local_prev <= local_irq_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state   <= ST_IDLE;
         cause_q <= '0;
      end else begin
         state   <= state_next;
         cause_q <= cause_next;
      end
   end

   always_comb begin
      state_next = state;
      cause_next = cause_q;
      case (state)
         ST_IDLE: begin
            if (win_valid) begin
               state_next = ST_REQ;
               cause_next = win_cause;
            end
         end
         ST_REQ: begin
            if (ack_valid || !elig_ext[cause_q]) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign irq_req_out   = (state == ST_REQ);
   assign irq_cause_out = cause_q;
   assign mie_out       = mstatus_mie;

endmodule

// File: tb/tb_m_irq_csr_unit.sv
// Directed self-checking bench for m_irq_csr_unit (NUM_LOCAL=4).
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_m_irq_csr_unit;

   logic        clk;
   logic        rst_n;
   logic [11:0] csr_addr;
   logic        csr_wr_en;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        ext_irq, sw_irq, timer_irq;
   logic [3:0]  local_irq;
   logic        trap_taken, mret, irq_req, irq_ack, mie_o;
   logic [4:0]  irq_cause;
   logic [31:0] rd;

   int checks   = 0;
   int failures = 0;

   m_irq_csr_unit #(.NUM_LOCAL(4)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .csr_addr_in   (csr_addr),
      .csr_wr_en_in  (csr_wr_en),
      .csr_op_in     (csr_op),
      .csr_wdata_in  (csr_wdata),
      .csr_rdata_out (csr_rdata),
      .ext_irq_in    (ext_irq),
      .sw_irq_in     (sw_irq),
      .timer_irq_in  (timer_irq),
      .local_irq_in  (local_irq),
      .trap_taken_in (trap_taken),
      .mret_in       (mret),
      .irq_req_out   (irq_req),
      .irq_cause_out (irq_cause),
      .irq_ack_in    (irq_ack),
      .mie_out       (mie_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_do(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
      csr_addr  = addr;
      csr_op    = op;
      csr_wdata = data;
      csr_wr_en = 1'b1;
      tick();
      csr_wr_en = 1'b0;
      csr_op    = 2'b00;
   endtask

   task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
      csr_addr = addr;
      #1;
      data = csr_rdata;
   endtask

   task automatic pulse_ack_mret();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; csr_addr = '0; csr_wr_en = 1'b0; csr_op = '0; csr_wdata = '0;
      ext_irq = 0; sw_irq = 0; timer_irq = 0; local_irq = '0;
      trap_taken = 0; mret = 0; irq_ack = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      csr_read(12'h300, rd);
      checks++; if (rd !== 32'h0000_1880) begin failures++; $display("[TB] FAIL reset_mstatus got=%h exp=%h", rd, 32'h1880); end
      csr_read(12'h304, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mie got=%h exp=0", rd); end
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mip got=%h exp=0", rd); end
      checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", irq_req); end
      checks++; if (mie_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mie_out got=%b exp=0", mie_o); end
   endtask

   task automatic test_priority();
      csr_do(12'h304, 2'b01, 32'h0001_0888);
      csr_do(12'h300, 2'b10, 32'h0000_0008);
      ext_irq = 1; sw_irq = 1; timer_irq = 1; local_irq[0] = 1'b1;
      tick();
      local_irq[0] = 1'b0;
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd11) begin failures++; $display("[TB] FAIL prio_mei req=%b cause=%0d exp req=1 cause=11", irq_req, irq_cause); end
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0001_0888) begin failures++; $display("[TB] FAIL prio_mip got=%h exp=%h", rd, 32'h10888); end
      pulse_ack_mret();
      ext_irq = 0;
      checks++; if (irq_req !== 1'b0 || mie_o !== 1'b0) begin failures++; $display("[TB] FAIL prio_ack req=%b mie=%b exp 0/0", irq_req, mie_o); end
      mret = 1; tick(); mret = 0;
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd3) begin failures++; $display("[TB] FAIL prio_msi req=%b cause=%0d exp req=1 cause=3", irq_req, irq_cause); end
      pulse_ack_mret();
      sw_irq = 0;
      mret = 1; tick(); mret = 0;
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd7) begin failures++; $display("[TB] FAIL prio_mti req=%b cause=%0d exp req=1 cause=7", irq_req, irq_cause); end
      pulse_ack_mret();
      timer_irq = 0;
      mret = 1; tick(); mret = 0;
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd16) begin failures++; $display("[TB] FAIL prio_local req=%b cause=%0d exp req=1 cause=16", irq_req, irq_cause); end
      pulse_ack_mret();
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL prio_ack_clears got=%h exp=0", rd); end
   endtask

   task automatic test_local_edge();
      csr_do(12'h304, 2'b01, 32'h0004_0000);
      local_irq[2] = 1'b1; tick(); local_irq[2] = 1'b0;
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0004_0000) begin failures++; $display("[TB] FAIL edge_pending got=%h exp=%h", rd, 32'h40000); end
      tick();
      checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL edge_masked req=%b exp=0", irq_req); end
      csr_do(12'h300, 2'b10, 32'h0000_0008);
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd18) begin failures++; $display("[TB] FAIL edge_req req=%b cause=%0d exp req=1 cause=18", irq_req, irq_cause); end
      pulse_ack_mret();
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0 || irq_req !== 1'b0) begin failures++; $display("[TB] FAIL edge_ack mip=%h req=%b exp 0/0", rd, irq_req); end
   endtask

   task automatic test_withdraw();
      csr_do(12'h304, 2'b01, 32'h0000_0080);
      timer_irq = 1;
      csr_do(12'h300, 2'b10, 32'h0000_0008);
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd7) begin failures++; $display("[TB] FAIL wd_req req=%b cause=%0d exp req=1 cause=7", irq_req, irq_cause); end
      csr_do(12'h304, 2'b11, 32'h0000_0080);
      tick();
      checks++; if (irq_req !== 1'b0) begin failures++; $display("[TB] FAIL wd_drop req=%b exp=0", irq_req); end
      checks++; if (mie_o !== 1'b1) begin failures++; $display("[TB] FAIL wd_mie got=%b exp=1", mie_o); end
      timer_irq = 0;
   endtask

   task automatic test_collision();
      csr_do(12'h304, 2'b01, 32'h0000_0008);
      sw_irq = 1;
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd3) begin failures++; $display("[TB] FAIL col_req req=%b cause=%0d exp req=1 cause=3", irq_req, irq_cause); end
      csr_addr = 12'h300; csr_op = 2'b01; csr_wdata = 32'h8; csr_wr_en = 1'b1; irq_ack = 1'b1;
      tick();
      csr_wr_en = 1'b0; csr_op = 2'b00; irq_ack = 1'b0; sw_irq = 0;
      checks++; if (mie_o !== 1'b1) begin failures++; $display("[TB] FAIL col_write_wins mie=%b exp=1", mie_o); end
      csr_read(12'h300, rd);
      checks++; if (rd !== 32'h0000_1808) begin failures++; $display("[TB] FAIL col_mstatus got=%h exp=%h", rd, 32'h1808); end
      local_irq[0] = 1'b1;
      csr_addr = 12'h344; csr_op = 2'b11; csr_wdata = 32'h0001_0000; csr_wr_en = 1'b1;
      tick();
      csr_wr_en = 1'b0; csr_op = 2'b00; local_irq[0] = 1'b0;
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("[TB] FAIL col_set_wins got=%h exp=%h", rd, 32'h10000); end
      csr_do(12'h344, 2'b11, 32'h0001_0000);
      csr_read(12'h344, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL col_clear got=%h exp=0", rd); end
   endtask

   task automatic test_async_reset();
      csr_do(12'h304, 2'b01, 32'h0000_0800);
      ext_irq = 1;
      tick();
      checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd11) begin failures++; $display("[TB] FAIL ar_req req=%b cause=%0d exp req=1 cause=11", irq_req, irq_cause); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (irq_req !== 1'b0 || mie_o !== 1'b0) begin failures++; $display("[TB] FAIL ar_drop req=%b mie=%b exp 0/0", irq_req, mie_o); end
      ext_irq = 0;
      tick();
      rst_n = 1'b1;
      tick();
      csr_read(12'h300, rd);
      checks++; if (rd !== 32'h0000_1880) begin failures++; $display("[TB] FAIL ar_mstatus got=%h exp=%h", rd, 32'h1880); end
      csr_read(12'h304, rd);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL ar_mie got=%h exp=0", rd); end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_local_edge();
      test_withdraw();
      test_collision();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/m_irq_csr_unit.md
# m_irq_csr_unit

Parametrised machine-mode interrupt CSR unit for the RV32 core. It replaces the single-bit status register with a combined mstatus/mie/mip register set. It adds NUM_LOCAL edge-latched platform interrupts, set/clear CSR operations, a fixed-priority arbiter, and a request/acknowledge handshake to the trap sequencer. It sits beside the CSR file in the execute stage and drives the core's interrupt-entry path.

## Interface
- NUM_LOCAL, 4: number of local platform interrupts, legal 1..16, mapped to cause/bit 16+i.
- clk_in  in  1  core clock
- rst_n_in  in  1  asynchronous, active-low reset
- csr_addr_in  in  12  CSR address: 0x300 mstatus, 0x304 mie, 0x344 mip
- csr_wr_en_in  in  1  CSR access commits this cycle
- csr_op_in  in  2  01 write, 10 set (OR), 11 clear (AND-NOT), 00 no write
- csr_wdata_in  in  32  CSR operand
- csr_rdata_out  out  32  combinational read of the addressed register; 0 for unmapped addresses
- ext_irq_in, sw_irq_in, timer_irq_in  in  1 each  level-sensitive MEI/MSI/MTI
- local_irq_in  in  NUM_LOCAL  rising-edge-sensitive local interrupts
- trap_taken_in  in  1  synchronous exception entry
- mret_in  in  1  mret retire
- irq_req_out  out  1  interrupt request to the trap sequencer
- irq_cause_out  out  5  cause code of the requested interrupt
- irq_ack_in  in  1  sequencer accepts the request; counts as trap entry
- mie_out  out  1  mstatus.MIE

## Operation
- mstatus read value: MIE at bit 3, MPIE at bit 7, MPP[12:11] hardwired 11, all other bits 0. Only bits 3 and 7 are writable.
- mie register: writable bits are 3, 7, 11 and 16..16+NUM_LOCAL-1. All other bits read 0.
- mip register, bits 3/7/11: read-only live reflection of sw/timer/ext levels.
- mip register, bits 16+i: latched pending. A rising edge on local_irq_in[i] (versus the registered previous sample) sets the bit.
- A local pending bit is cleared by a CSR write/clear of 0 to that bit, or by irq_ack_in while irq_cause_out==16+i.
- If a set and a clear of the same pending bit occur in the same cycle, the set wins.
- Eligible set: mip & mie, gated by MIE.
- Priority: MEI(11) > MSI(3) > MTI(7) > local, with the lowest index highest among locals.
- Event priority per cycle, highest first:
  - CSR write to mstatus;
  - irq_ack_in or trap_taken_in: MPIE<=MIE, MIE<=0;
  - mret_in: MIE<=MPIE, MPIE<=1.
  - Lower-priority events in the same cycle are dropped.
- Handshake FSM, two states:
  - IDLE: if the eligible set is non-empty, go to REQ. Register irq_req_out=1 and irq_cause_out = winner.
  - REQ: irq_cause_out is frozen, and is not re-arbitrated for higher-priority arrivals.
    - irq_ack_in -> IDLE, request dropped next cycle.
    - The frozen cause becoming ineligible (MIE or enable cleared, level dropped, pending cleared) -> IDLE, request withdrawn next cycle.
  - irq_ack_in in IDLE is ignored.
- All arithmetic is bitwise. Unused mie/mip bits above 16+NUM_LOCAL-1 are constant 0.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - MIE=0, MPIE=1, mie=0, local pending=0, edge history=0;
  - FSM=IDLE, irq_req_out=0, irq_cause_out=0, mie_out=0.
- Reset mid-request: irq_req_out drops immediately and asynchronously. No ack is required.
- A CSR write is visible on csr_rdata_out and mie_out the next cycle. Reads are zero-latency.
- Level interrupt latency: input high at edge N -> irq_req_out high after edge N+1.
- Local edge latency: edge sampled at N -> pending after N -> request after N+1.
- Ack at edge N: request low and MIE=0 after N. A new request is possible no earlier than after N+1, and only if MIE is re-enabled.
- A local rising edge held high produces exactly one pending set.

## Structure
- Package irq_csr_pkg holds:
  - CSR address constants;
  - csr_op encodings;
  - cause codes 3/7/11;
  - LOCAL_BASE=16;
  - FSM state typedef.
- Sub-module irq_prio_enc: a combinational fixed-priority encoder over a (16+NUM_LOCAL)-bit eligible vector. Outputs valid + 5-bit cause.

## Test plan
- Reset: after rst_n_in low then high, mstatus reads 0x00001880, mie reads 0, mip reads 0, irq_req_out=0.
- Priority: mie=0x00010888, MIE=1, all sources raised in one cycle -> irq_cause_out=11. Ack, then mret -> next request cause=3, then 7, then 16.
- Local edge: pulse local_irq_in[2] for 1 cycle with mie bit18 set and MIE=0 -> mip=0x00040000, no request. Set MIE -> request cause 18. Ack -> mip bit18 clears.
- Withdraw: request active for cause 7, then CSR clear mie with 0x80 -> irq_req_out low next cycle, FSM IDLE, MIE unchanged.
- Collision: CSR write mstatus=0x8 in the same cycle as irq_ack_in -> MIE=1 after the edge (write wins). A clear of bit16 coincident with a local[0] edge -> bit16 stays 1.
- Async reset while irq_req_out=1 -> output low before the next clock edge.
